// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: replays queued {op,len} commands onto registered j/k and checks the JK flip-flop's q against a model
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready = FIFO not full
//   cmd_op, cmd_len       {j,k} operation and cycle count (0 acts as 1)
//   j, k                  registered drive to the flip-flop
//   q                     flip-flop output fed back
//   q_exp                 modelled flip-flop state
//   busy, done, err       in RUN, last-command-finished pulse, sticky mismatch
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  input  logic             q,
  output logic             q_exp,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t            state_q, state_d;
  logic [CNT_W+1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              j_q, j_d, k_q, k_d, done_q, done_d;
  logic              q_exp_q, q_exp_d, check_en_q, check_en_d, err_q, err_d;
  logic              push, pop, empty;
  logic [1:0]        head_op;
  logic [CNT_W-1:0]  head_len;
  assign empty     = count_q == '0;
  assign cmd_ready = count_q != (AW+1)'(DEPTH);
  assign push      = cmd_valid & cmd_ready;
  assign {head_op, head_len} = mem_q[rd_ptr_q];
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    j_d        = j_q;
    k_d        = k_q;
    done_d     = 1'b0;
    pop        = 1'b0;
    // rem counts the cycles left after the current one, so rem==0 in RUN is the last drive cycle
    if (state_q == IDLE || rem_q == '0) begin
      if (!empty) begin
        pop        = 1'b1;
        {j_d, k_d} = head_op;
        rem_d      = head_len == '0 ? '0 : head_len - CNT_W'(1);
        state_d    = RUN;
      end else begin
        {j_d, k_d} = 2'b00;
        state_d    = IDLE;
        done_d     = state_q == RUN;
      end
    end else begin
      rem_d = rem_q - CNT_W'(1);
    end
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    q_exp_d    = (j_q & ~q_exp_q) | (~k_q & q_exp_q);
    // q becomes known once a SET or RESET has been applied to the flip-flop
    check_en_d = check_en_q | (j_q ^ k_q);
    err_d      = err_q | (check_en_q & (q ^ q_exp_q));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rem_q      <= '0;
      j_q        <= 1'b0;
      k_q        <= 1'b0;
      done_q     <= 1'b0;
      q_exp_q    <= 1'b0;
      check_en_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      j_q        <= j_d;
      k_q        <= k_d;
      done_q     <= done_d;
      q_exp_q    <= q_exp_d;
      check_en_q <= check_en_d;
      err_q      <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_len};
  end
  assign j     = j_q;
  assign k     = k_q;
  assign busy  = state_q == RUN;
  assign done  = done_q;
  assign q_exp = q_exp_q;
  assign err   = err_q;
endmodule
